// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Column drive and row decode helpers live here so the top stays focused on sequencing.
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    localparam logic [COLS-1:0] COLS_RESET = 4'b1110;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } scan_state_t;

    function automatic logic [COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Lowest-numbered low row wins; result is meaningless when no row is low.
    function automatic logic [1:0] lowest_low(input logic [ROWS-1:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad row lines.
// Resets to all-ones so the scanner sees "no key" until real samples arrive.
module keypad_row_sync
    import keypad_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [ROWS-1:0] rows,
    output logic [ROWS-1:0] synced
);

    logic [ROWS-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage  <= '1;
            synced <= '1;
        end else begin
            stage  <= rows;
            synced <= stage;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low column, debounces presses and releases
// on prescaled ticks, and hands out one key code per press over a valid/ack handshake.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROWS-1:0]  rows,
    output logic [COLS-1:0]  cols,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ack,
    output logic             overrun
);

    localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_SCANS);

    logic [ROWS-1:0]          rows_sync;
    logic [SCAN_DIV_BITS-1:0] prescale;
    logic                     tick;
    logic                     any_low;
    logic [1:0]               win_row;
    logic [1:0]               col_idx;
    logic [1:0]               row_idx;
    logic [3:0]               deb_cnt;
    scan_state_t              state;

    keypad_row_sync u_row_sync (
        .clk    (clk),
        .reset  (reset),
        .rows   (rows),
        .synced (rows_sync)
    );

    assign tick    = (prescale == '1);
    assign any_low = (rows_sync != '1);
    assign win_row = lowest_low(rows_sync);

    // Ack is applied first so a confirm on the same edge overrides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            prescale  <= '0;
            col_idx   <= 2'd0;
            cols      <= COLS_RESET;
            row_idx   <= 2'd0;
            deb_cnt   <= 4'd0;
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            prescale <= prescale + 1'b1;

            if (key_ack && key_valid) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end

            if (tick) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            row_idx <= win_row;
                            deb_cnt <= 4'd1;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            cols    <= col_drive(col_idx + 2'd1);
                        end
                    end
                    DEBOUNCE: begin
                        if (any_low && win_row == row_idx) begin
                            if (deb_cnt + 4'd1 == DEB_MAX) begin
                                state     <= HELD;
                                deb_cnt   <= 4'd0;
                                key_code  <= {row_idx, col_idx};
                                key_valid <= 1'b1;
                                overrun   <= !key_ack && (key_valid || overrun);
                            end else begin
                                deb_cnt <= deb_cnt + 4'd1;
                            end
                        end else begin
                            state   <= SCAN;
                            col_idx <= col_idx + 2'd1;
                            cols    <= col_drive(col_idx + 2'd1);
                        end
                    end
                    HELD: begin
                        // No auto-repeat: only a debounced full release leaves HELD.
                        if (!any_low) begin
                            if (deb_cnt + 4'd1 == DEB_MAX) begin
                                state   <= SCAN;
                                deb_cnt <= 4'd0;
                                col_idx <= col_idx + 2'd1;
                                cols    <= col_drive(col_idx + 2'd1);
                            end else begin
                                deb_cnt <= deb_cnt + 4'd1;
                            end
                        end else begin
                            deb_cnt <= 4'd0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical key-matrix model drives rows,
// and a press-level reference model predicts every output on every cycle.
module tb_keypad_scanner;

    localparam int DIV_BITS = 2;
    localparam int DEB      = 4;
    localparam int PERIOD   = 1 << DIV_BITS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack = 1'b0;
    logic       overrun;
    logic [15:0] pressed = 16'h0000;

    int checks = 0;
    int passes = 0;

    keypad_scanner #(
        .SCAN_DIV_BITS  (DIV_BITS),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && cols[c] === 1'b0) rows[r] = 1'b0;
    end

    // Reference model: tracks the scanned column, the candidate press and how long it has
    // been stable, and the release count while a key is held.
    bit         m_ready = 0;
    int         m_clocks, m_col, m_pend, m_stable, m_hold, m_rel;
    logic [3:0] m_s1, m_s2;
    bit         m_valid, m_over;
    int         m_code;

    function automatic logic [3:0] matrix_rows(input int col);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++)
            if (pressed[i*4+col]) r[i] = 1'b0;
        return r;
    endfunction

    function automatic int first_low(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (!v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        logic [3:0] raw, seen;
        int         r;
        bit         confirm;
        int         new_code;
        if (reset) begin
            m_ready = 1; m_clocks = 0; m_col = 0; m_pend = -1; m_stable = 0;
            m_hold = 0; m_rel = 0; m_s1 = 4'hF; m_s2 = 4'hF;
            m_valid = 0; m_over = 0; m_code = 0;
        end else if (m_ready) begin
            raw  = matrix_rows(m_col);
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = raw;
            confirm = 0;
            new_code = 0;
            if (m_clocks % PERIOD == PERIOD - 1) begin
                r = first_low(seen);
                if (m_hold) begin
                    if (r < 0) begin
                        m_rel++;
                        if (m_rel == DEB) begin
                            m_hold = 0;
                            m_rel = 0;
                            m_col = (m_col + 1) % 4;
                        end
                    end else m_rel = 0;
                end else if (m_pend >= 0) begin
                    if (r == m_pend) begin
                        m_stable++;
                        if (m_stable == DEB) begin
                            confirm = 1;
                            new_code = m_pend * 4 + m_col;
                            m_pend = -1;
                            m_hold = 1;
                            m_rel = 0;
                        end
                    end else begin
                        m_pend = -1;
                        m_col = (m_col + 1) % 4;
                    end
                end else if (r >= 0) begin
                    m_pend = r;
                    m_stable = 1;
                end else m_col = (m_col + 1) % 4;
            end
            m_clocks++;
            if (confirm) begin
                m_over  = key_ack ? 0 : (m_valid || m_over);
                m_valid = 1;
                m_code  = new_code;
            end else if (key_ack && m_valid) begin
                m_valid = 0;
                m_over  = 0;
            end
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    endtask

    always @(negedge clk) begin
        if (m_ready) begin
            check_output("model cols", {4'h0, cols}, {4'h0, ~(4'b0001 << m_col)});
            check_output("model key_code", {4'h0, key_code}, 8'(m_code));
            check_output("model key_valid", {7'h0, key_valid}, {7'h0, m_valid});
            check_output("model overrun", {7'h0, overrun}, {7'h0, m_over});
        end
    end

    task automatic wait_cols(input logic [3:0] target, input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (cols !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(name, {4'h0, cols}, {4'h0, target});
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (key_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(name, {7'h0, key_valid}, 8'h01);
    endtask

    task automatic wait_code(input logic [3:0] code, input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (!(key_valid === 1'b1 && key_code === code) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(name, {4'h0, key_code}, {4'h0, code});
    endtask

    task automatic apply_stimulus(input string what, input int key, input bit down);
        pressed[key] = down;
    endtask

    task automatic pulse_ack;
        @(posedge clk); #2 key_ack = 1'b1;
        @(posedge clk); #2 key_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rot [4];
        rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;

        // Reset and idle rotation
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check_output("reset cols", {4'h0, cols}, 8'h0E);
        check_output("reset key_valid", {7'h0, key_valid}, 8'h00);
        check_output("reset key_code", {4'h0, key_code}, 8'h00);
        check_output("reset overrun", {7'h0, overrun}, 8'h00);
        for (int i = 0; i < 4; i++) wait_cols(rot[i], 2 * PERIOD, "idle rotation");

        // Single press of key 9, held with no repeat, then acknowledged
        apply_stimulus("press 9", 9, 1'b1);
        wait_valid(200, "press 9 valid");
        check_output("press 9 code", {4'h0, key_code}, 8'h09);
        repeat (20 * PERIOD) @(posedge clk);
        @(negedge clk);
        check_output("held cols", {4'h0, cols}, 8'h0D);
        check_output("held valid", {7'h0, key_valid}, 8'h01);
        pulse_ack;
        check_output("ack clears valid", {7'h0, key_valid}, 8'h00);
        apply_stimulus("release 9", 9, 1'b0);
        wait_cols(4'b1011, 60, "release resumes scan");

        // Bounce on row 0: low for two ticks only
        wait_cols(4'b1110, 40, "reach col 0");
        apply_stimulus("bounce 0", 0, 1'b1);
        repeat (2 * PERIOD) @(posedge clk);
        #2 apply_stimulus("bounce 0 off", 0, 1'b0);
        wait_cols(4'b1101, 40, "bounce rotation resumes");
        check_output("bounce no valid", {7'h0, key_valid}, 8'h00);

        // Overrun: key 9 then key F with no ack in between
        apply_stimulus("press 9", 9, 1'b1);
        wait_valid(200, "overrun first valid");
        check_output("overrun first code", {4'h0, key_code}, 8'h09);
        apply_stimulus("release 9", 9, 1'b0);
        wait_cols(4'b1011, 60, "overrun release");
        apply_stimulus("press F", 15, 1'b1);
        wait_code(4'hF, 200, "overrun second code");
        check_output("overrun valid", {7'h0, key_valid}, 8'h01);
        check_output("overrun flag", {7'h0, overrun}, 8'h01);
        pulse_ack;
        check_output("ack clears valid 2", {7'h0, key_valid}, 8'h00);
        check_output("ack clears overrun", {7'h0, overrun}, 8'h00);
        apply_stimulus("release F", 15, 1'b0);
        wait_cols(4'b1110, 60, "release F");

        // Ack coincides with the confirming tick of key 5
        apply_stimulus("press 2", 2, 1'b1);
        wait_valid(200, "collision first valid");
        check_output("collision first code", {4'h0, key_code}, 8'h02);
        apply_stimulus("release 2", 2, 1'b0);
        wait_cols(4'b0111, 60, "release 2");
        apply_stimulus("press 5", 5, 1'b1);
        wait_cols(4'b1101, 60, "reach col 1");
        repeat (DEB * PERIOD - 1) @(posedge clk);
        #2 key_ack = 1'b1;
        @(posedge clk);
        #2 key_ack = 1'b0;
        @(negedge clk);
        check_output("collision valid", {7'h0, key_valid}, 8'h01);
        check_output("collision code", {4'h0, key_code}, 8'h05);
        check_output("collision overrun", {7'h0, overrun}, 8'h00);
        apply_stimulus("release 5", 5, 1'b0);
        wait_cols(4'b1011, 60, "release 5");

        // Reset while key 9 is held; it must be reported again afterwards
        apply_stimulus("press 9", 9, 1'b1);
        wait_code(4'h9, 200, "pre-reset code");
        repeat (3 * PERIOD) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("mid-held reset cols", {4'h0, cols}, 8'h0E);
        check_output("mid-held reset valid", {7'h0, key_valid}, 8'h00);
        check_output("mid-held reset code", {4'h0, key_code}, 8'h00);
        @(posedge clk);
        #2 reset = 1'b0;
        wait_valid(200, "re-press valid");
        check_output("re-press code", {4'h0, key_code}, 8'h09);
        check_output("re-press cols", {4'h0, cols}, 8'h0D);
        apply_stimulus("release 9", 9, 1'b0);
        repeat (10) @(posedge clk);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
